// File: rtl/mult_rr_scheduler.sv
// Two-requester front end for one sequential shift-add multiplier engine.
// A round-robin grant takes one operand pair per op; N iterations later the product pulses back to its owner.
module mult_rr_scheduler #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0_valid,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  output logic           req0_ready,
  input  logic           req1_valid,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic           req1_ready,
  output logic           rsp0_valid,
  output logic           rsp1_valid,
  output logic [2*N-1:0] rsp_z,
  output logic           busy,
  output logic           owner
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state, w_state_nxt;
  logic [2*N-1:0] r_mcand, r_acc, r_rsp_z, w_acc_nxt;
  logic [N-1:0]   r_mplier, w_a, w_b;
  logic [CW-1:0]  r_cnt;
  logic           r_owner, r_last_grant, r_rsp0_valid, r_rsp1_valid;
  logic           w_gnt_vld, w_gnt_idx, w_accept, w_last_iter;

  // On a tie the requester that did not win last time gets the grant.
  always_comb begin
    w_gnt_vld = req0_valid | req1_valid;
    w_gnt_idx = 1'b0;
    if (req0_valid && req1_valid) w_gnt_idx = ~r_last_grant;
    else if (req1_valid)          w_gnt_idx = 1'b1;
  end

  assign w_accept    = (r_state == S_IDLE) && w_gnt_vld;
  assign req0_ready  = w_accept && !w_gnt_idx;
  assign req1_ready  = w_accept &&  w_gnt_idx;
  assign w_a         = w_gnt_idx ? req1_a : req0_a;
  assign w_b         = w_gnt_idx ? req1_b : req0_b;
  assign w_last_iter = (r_state == S_CALC) && (r_cnt == LAST);
  assign w_acc_nxt   = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_CALC;
      S_CALC:  if (w_last_iter) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_rsp_z      <= '0;
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
    end else begin
      r_rsp0_valid <= 1'b0;
      r_rsp1_valid <= 1'b0;
      if (w_accept) begin
        r_mcand      <= {{N{1'b0}}, w_a};
        r_mplier     <= w_b;
        r_acc        <= '0;
        r_cnt        <= '0;
        r_owner      <= w_gnt_idx;
        r_last_grant <= w_gnt_idx;
      end else if (r_state == S_CALC) begin
        // Fixed N iterations regardless of operand value keeps latency constant.
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (w_last_iter) begin
          r_rsp_z      <= w_acc_nxt;
          r_rsp0_valid <= ~r_owner;
          r_rsp1_valid <=  r_owner;
        end
      end
    end
  end

  assign rsp_z      = r_rsp_z;
  assign rsp0_valid = r_rsp0_valid;
  assign rsp1_valid = r_rsp1_valid;
  assign busy       = (r_state != S_IDLE);
  assign owner      = r_owner;

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed bench for mult_rr_scheduler: vector table of single ops plus arbitration/reset sequences.
module tb_mult_rr_scheduler;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0_valid, req1_valid;
  logic [N-1:0]   req0_a, req0_b, req1_a, req1_b;
  logic           req0_ready, req1_ready;
  logic           rsp0_valid, rsp1_valid, busy, owner;
  logic [2*N-1:0] rsp_z;

  int n_cmp = 0;
  int n_bad = 0;

  mult_rr_scheduler #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_z(rsp_z),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         o;
    logic [7:0] z;
  } rsp_t;

  int   cyc = 0;
  int   both_ready = 0;
  int   both_rsp = 0;
  int   pulses = 0;
  int   acc_cyc[$];
  bit   grants[$];
  rsp_t rsps[$];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst) begin
      if (req0_ready && req1_ready) both_ready++;
      if (req0_valid && req0_ready) begin grants.push_back(1'b0); acc_cyc.push_back(cyc); end
      if (req1_valid && req1_ready) begin grants.push_back(1'b1); acc_cyc.push_back(cyc); end
    end
  end

  always @(negedge clk) begin
    if (rsp0_valid && rsp1_valid) both_rsp++;
    if (rsp0_valid || rsp1_valid) begin
      rsp_t r;
      r.o = rsp1_valid;
      r.z = rsp_z;
      rsps.push_back(r);
      pulses++;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_mon();
    acc_cyc.delete();
    grants.delete();
    rsps.delete();
  endtask

  task automatic do_op(input bit r, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] z, input string nm);
    int e;
    @(negedge clk);
    if (r) begin req1_valid = 1'b1; req1_a = a; req1_b = b; end
    else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; end
    #1;
    chk({nm, "_ready"}, int'(r ? req1_ready : req0_ready), 1);
    chk({nm, "_other_ready"}, int'(r ? req0_ready : req1_ready), 0);
    @(negedge clk);
    // Scramble operands after the accept edge; the engine must hold its copy.
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 4'($urandom); req0_b = 4'($urandom);
    req1_a = 4'($urandom); req1_b = 4'($urandom);
    chk({nm, "_busy"}, int'(busy), 1);
    e = 0;
    while (!(rsp0_valid || rsp1_valid) && e < 20) begin @(negedge clk); e++; end
    // e counts edges after the accept edge; pulse appears after N of them.
    chk({nm, "_latency"}, e, N);
    chk({nm, "_z"}, int'(rsp_z), int'(z));
    chk({nm, "_rspv"}, int'({rsp1_valid, rsp0_valid}), r ? 2 : 1);
    chk({nm, "_owner"}, int'(owner), int'(r));
    @(negedge clk);
    chk({nm, "_pulse_end"}, int'({rsp1_valid, rsp0_valid}), 0);
    chk({nm, "_idle"}, int'(busy), 0);
  endtask

  typedef struct {
    bit         r;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] z;
  } vec_t;

  initial begin
    vec_t vt[7];
    logic [3:0] o0a[3], o0b[3], o1a[3], o1b[3];
    logic [7:0] exp6[6];
    int t, n0, n1, p0;

    vt[0] = '{1'b0, 4'd14, 4'd3,  8'd42};
    vt[1] = '{1'b0, 4'd0,  4'd15, 8'd0};
    vt[2] = '{1'b1, 4'd15, 4'd0,  8'd0};
    vt[3] = '{1'b1, 4'd15, 4'd15, 8'd225};
    vt[4] = '{1'b0, 4'd1,  4'd1,  8'd1};
    vt[5] = '{1'b1, 4'd10, 4'd6,  8'd60};
    vt[6] = '{1'b0, 4'd9,  4'd7,  8'd63};

    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    repeat (2) @(negedge clk);
    chk("rst_outputs", int'({req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, owner}), 0);
    chk("rst_z", int'(rsp_z), 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) do_op(vt[i].r, vt[i].a, vt[i].b, vt[i].z, $sformatf("vec%0d", i));

    // req1 back-to-back with valid held: accepts exactly N+2 cycles apart.
    clear_mon();
    @(negedge clk);
    req1_valid = 1'b1; req1_a = 4'd3; req1_b = 4'd5;
    t = 0;
    while (acc_cyc.size() < 1 && t < 50) begin @(negedge clk); t++; end
    req1_a = 4'd8; req1_b = 4'd10;
    t = 0;
    while (acc_cyc.size() < 2 && t < 50) begin @(negedge clk); t++; end
    req1_valid = 1'b0;
    t = 0;
    while (rsps.size() < 2 && t < 50) begin @(negedge clk); t++; end
    chk("b2b_accepts", acc_cyc.size(), 2);
    chk("b2b_gap", acc_cyc[1] - acc_cyc[0], N + 2);
    chk("b2b_z0", int'(rsps[0].z), 15);
    chk("b2b_z1", int'(rsps[1].z), 80);
    chk("b2b_owner", int'({rsps[1].o, rsps[0].o}), 3);

    // Reset two cycles into CALC drops the op silently.
    do_op(1'b0, 4'd5, 4'd5, 8'd25, "pre_rst");
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 4'd9; req0_b = 4'd9;
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_z", int'(rsp_z), 0);
    p0 = pulses;
    @(negedge clk);
    rst = 1'b0;
    repeat (N + 4) @(negedge clk);
    chk("midrst_no_pulse", pulses - p0, 0);
    do_op(1'b0, 4'd13, 4'd11, 8'd143, "post_rst");

    // Both valid for six ops straight after reset: strict alternation starting at req0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_mon();
    o0a = '{4'd12, 4'd7,  4'd15}; o0b = '{4'd15, 4'd9,  4'd15};
    o1a = '{4'd15, 4'd11, 4'd1};  o1b = '{4'd15, 4'd13, 4'd6};
    exp6 = '{8'd180, 8'd225, 8'd63, 8'd143, 8'd225, 8'd6};
    t = 0;
    while (rsps.size() < 6 && t < 200) begin
      n0 = 0; n1 = 0;
      foreach (grants[k]) if (grants[k]) n1++; else n0++;
      req0_valid = (n0 < 3); req1_valid = (n1 < 3);
      req0_a = o0a[n0 < 3 ? n0 : 2]; req0_b = o0b[n0 < 3 ? n0 : 2];
      req1_a = o1a[n1 < 3 ? n1 : 2]; req1_b = o1b[n1 < 3 ? n1 : 2];
      @(negedge clk);
      t++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("rr_count", rsps.size(), 6);
    chk("rr_grants", grants.size(), 6);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rr_grant%0d", i), int'(grants[i]), i % 2);
      chk($sformatf("rr_owner%0d", i), int'(rsps[i].o), i % 2);
      chk($sformatf("rr_z%0d", i), int'(rsps[i].z), int'(exp6[i]));
    end

    chk("ready_exclusive", both_ready, 0);
    chk("rsp_exclusive", both_rsp, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
